// File: rtl/program_load_controller_pkg.sv
// rtl/program_load_controller_pkg.sv - shared types and constants for the UART program loader
package program_load_controller_pkg;

    typedef enum logic [2:0] {
        WAIT_SYNC,
        LEN,
        DATA,
        WRITE,
        RUN
    } loader_state_t;

    localparam logic [7:0] LOADER_START_BYTE = 8'hA5;
    localparam int         LOADER_LEN_BYTES  = 2;

endpackage

// File: rtl/loader_byte_assembler.sv
// rtl/loader_byte_assembler.sv - packs little-endian bytes into 32-bit words
module loader_byte_assembler (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [23:0] r_shift;
    logic [1:0]  r_byte_cnt;

    // The fourth byte is forwarded combinationally so the word lands one cycle after it arrives.
    assign o_word_valid = i_byte_valid && (r_byte_cnt == 2'd3);
    assign o_word       = {i_byte, r_shift};

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (i_byte_valid) begin
            r_shift    <= {i_byte, r_shift[23:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/program_load_controller.sv
// rtl/program_load_controller.sv - loads program memory from a UART frame and holds the core until done
module program_load_controller
    import program_load_controller_pkg::*;
#(
    parameter logic [7:0] START_BYTE     = LOADER_START_BYTE,
    parameter int         MAX_WORDS      = 1024,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_frame_err,
    input  logic        i_reload_req,
    input  logic [31:0] i_fetch_addr,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [31:0] o_mem_wdata,
    output logic        o_core_hold,
    output logic        o_load_done,
    output logic        o_load_error,
    output logic [15:0] o_words_loaded
);

    localparam int IDX_W     = $clog2(MAX_WORDS) + 1;
    localparam int TO_W      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int LEN_CNT_W = (LOADER_LEN_BYTES > 1) ? $clog2(LOADER_LEN_BYTES) : 1;
    localparam logic [LEN_CNT_W-1:0] LEN_LAST = LEN_CNT_W'(LOADER_LEN_BYTES - 1);
    localparam logic [15:0]          MAX_N    = 16'(MAX_WORDS);
    localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    loader_state_t        r_state;
    logic [LEN_CNT_W-1:0] r_len_cnt;
    logic [7:0]           r_len_lo;
    logic [15:0]          r_num_words;
    logic [IDX_W-1:0]     r_word_idx;
    logic [TO_W-1:0]      r_timeout_cnt;
    logic                 r_mem_we;
    logic [31:0]          r_mem_wdata;
    logic                 r_core_hold;
    logic                 r_load_done;
    logic                 r_load_error;
    logic [15:0]          r_words_loaded;

    logic        w_byte;
    logic        w_in_frame_data;
    logic        w_word_valid;
    logic [31:0] w_word;
    logic [15:0] w_len;
    logic        w_last_word;
    logic        w_timeout;

    // A framing error on the same strobe discards the byte.
    assign w_byte          = i_rx_valid && !i_rx_frame_err;
    assign w_in_frame_data = (r_state == DATA) || (r_state == WRITE);
    assign w_len           = {i_rx_data, r_len_lo};
    assign w_last_word     = (16'(r_word_idx) + 16'd1) == r_num_words;
    assign w_timeout       = ((r_state == LEN) || (r_state == DATA)) && !i_rx_valid
                             && (r_timeout_cnt == TO_LAST);

    loader_byte_assembler u_assembler (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (!w_in_frame_data),
        .i_byte_valid (w_byte && w_in_frame_data),
        .i_byte       (i_rx_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    assign o_mem_addr     = (r_state == RUN) ? i_fetch_addr : 32'({r_word_idx, 2'b00});
    assign o_mem_we       = r_mem_we;
    assign o_mem_wdata    = r_mem_wdata;
    assign o_core_hold    = r_core_hold;
    assign o_load_done    = r_load_done;
    assign o_load_error   = r_load_error;
    assign o_words_loaded = r_words_loaded;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= WAIT_SYNC;
            r_len_cnt      <= '0;
            r_len_lo       <= '0;
            r_num_words    <= '0;
            r_word_idx     <= '0;
            r_timeout_cnt  <= '0;
            r_mem_we       <= 1'b0;
            r_mem_wdata    <= '0;
            r_core_hold    <= 1'b1;
            r_load_done    <= 1'b0;
            r_load_error   <= 1'b0;
            r_words_loaded <= '0;
        end else begin
            r_mem_we <= 1'b0;

            if (i_rx_valid || !((r_state == LEN) || (r_state == DATA)))
                r_timeout_cnt <= '0;
            else
                r_timeout_cnt <= r_timeout_cnt + TO_W'(1);

            // The write already happened this cycle, so it counts even if the frame is abandoned now.
            if (r_state == WRITE) begin
                r_word_idx     <= r_word_idx + IDX_W'(1);
                r_words_loaded <= r_words_loaded + 16'd1;
            end

            case (r_state)
                WAIT_SYNC: begin
                    if (w_byte && (i_rx_data == START_BYTE)) begin
                        r_state        <= LEN;
                        r_load_error   <= 1'b0;
                        r_len_cnt      <= '0;
                        r_words_loaded <= '0;
                    end
                end
                RUN: begin
                    if (i_reload_req) begin
                        r_state     <= WAIT_SYNC;
                        r_core_hold <= 1'b1;
                        r_load_done <= 1'b0;
                    end
                end
                default: begin
                    if (i_reload_req) begin
                        r_state <= WAIT_SYNC;
                    end else if (i_rx_frame_err || w_timeout) begin
                        r_state      <= WAIT_SYNC;
                        r_load_error <= 1'b1;
                    end else if (r_state == LEN) begin
                        if (w_byte) begin
                            if (r_len_cnt == LEN_LAST) begin
                                if ((w_len == 16'd0) || (w_len > MAX_N)) begin
                                    r_state      <= WAIT_SYNC;
                                    r_load_error <= 1'b1;
                                end else begin
                                    r_num_words <= w_len;
                                    r_word_idx  <= '0;
                                    r_state     <= DATA;
                                end
                            end else begin
                                r_len_lo  <= i_rx_data;
                                r_len_cnt <= r_len_cnt + LEN_CNT_W'(1);
                            end
                        end
                    end else if (r_state == DATA) begin
                        if (w_word_valid) begin
                            r_state     <= WRITE;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= w_word;
                        end
                    end else begin
                        if (w_last_word) begin
                            r_state     <= RUN;
                            r_core_hold <= 1'b0;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_load_controller.sv
// tb/tb_program_load_controller.sv - self-checking bench for program_load_controller
module tb_program_load_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_frame_err;
    logic        reload_req;
    logic [31:0] fetch_addr;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    program_load_controller #(
        .START_BYTE     (8'hA5),
        .MAX_WORDS      (1024),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_rx_valid     (rx_valid),
        .i_rx_data      (rx_data),
        .i_rx_frame_err (rx_frame_err),
        .i_reload_req   (reload_req),
        .i_fetch_addr   (fetch_addr),
        .o_mem_addr     (mem_addr),
        .o_mem_we       (mem_we),
        .o_mem_wdata    (mem_wdata),
        .o_core_hold    (core_hold),
        .o_load_done    (load_done),
        .o_load_error   (load_error),
        .o_words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [95:0] bytes;
        logic [3:0]  n;
        logic [1:0]  gap;
        logic [1:0]  nw;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        done;
        logic        err;
        logic        hold;
        logic [15:0] words;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  obs_q[$];
    int   obs_rd = 0;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[7];

    always @(negedge clk) begin
        if (!reset && mem_we)
            obs_q.push_back('{addr: mem_addr, data: mem_wdata});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_sb(input string name);
        wr_t e;
        wr_t o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_rd >= obs_q.size()) begin
                bad++;
                $display("FAIL %s missing write: got none want %h@%h", name, e.data, e.addr);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL %s write: got %h@%h want %h@%h", name, o.data, o.addr, e.data, e.addr);
                end
            end
        end
        chk({name, " extra writes"}, 32'(obs_q.size() - obs_rd), 32'd0);
        obs_rd = obs_q.size();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ferr, input int gap);
        rx_valid     = 1'b1;
        rx_data      = b;
        rx_frame_err = ferr;
        @(posedge clk); #1;
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reload();
        reload_req = 1'b1;
        @(posedge clk); #1;
        reload_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vec_t v;
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_frame_err = 1'b0;
        reload_req = 1'b0; fetch_addr = 32'h40;

        //            bytes (byte0 in MSB)                 n  gap nw  w0            w1            done err hold words
        vecs[0] = '{96'hA5_02_00_78_56_34_12_EF_BE_AD_DE_00, 4'd11, 2'd0, 2'd2, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 16'd2};
        vecs[1] = '{96'h00_FF_00_00_00_00_00_00_00_00_00_00, 4'd2,  2'd2, 2'd0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 16'd2};
        vecs[2] = '{96'hA5_01_04_00_00_00_00_00_00_00_00_00, 4'd3,  2'd2, 2'd0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 16'd0};
        vecs[3] = '{96'hA5_01_00_11_22_33_44_00_00_00_00_00, 4'd7,  2'd2, 2'd1, 32'h44332211, 32'h0,        1'b1, 1'b0, 1'b0, 16'd1};
        vecs[4] = '{96'hA5_00_00_00_00_00_00_00_00_00_00_00, 4'd3,  2'd2, 2'd0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 16'd0};
        vecs[5] = '{96'hA5_00_04_AA_BB_CC_DD_00_00_00_00_00, 4'd7,  2'd2, 2'd1, 32'hDDCCBBAA, 32'h0,        1'b0, 1'b0, 1'b1, 16'd1};
        vecs[6] = '{96'hA5_02_00_01_00_00_00_02_00_00_00_00, 4'd11, 2'd1, 2'd2, 32'h00000001, 32'h00000002, 1'b1, 1'b0, 1'b0, 16'd2};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst core_hold", {31'd0, core_hold}, 32'd1);
        chk("rst load_done", {31'd0, load_done}, 32'd0);
        chk("rst load_error", {31'd0, load_error}, 32'd0);
        chk("rst words", {16'd0, words_loaded}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            pulse_reload();
            if (i > 0)
                chk($sformatf("v%0d err after reload", i), {31'd0, load_error}, {31'd0, vecs[i-1].err});
            if (v.nw >= 2'd1) exp_q.push_back('{addr: 32'h0, data: v.w0});
            if (v.nw >= 2'd2) exp_q.push_back('{addr: 32'h4, data: v.w1});
            for (int k = 0; k < int'(v.n); k++)
                send_byte(v.bytes[95-8*k -: 8], 1'b0, int'(v.gap));
            idle(3);
            check_sb($sformatf("v%0d", i));
            chk($sformatf("v%0d load_done", i), {31'd0, load_done}, {31'd0, v.done});
            chk($sformatf("v%0d load_error", i), {31'd0, load_error}, {31'd0, v.err});
            chk($sformatf("v%0d core_hold", i), {31'd0, core_hold}, {31'd0, v.hold});
            chk($sformatf("v%0d words", i), {16'd0, words_loaded}, {16'd0, v.words});
        end

        // core_hold release timing relative to the final write
        pulse_reload();
        exp_q.push_back('{addr: 32'h0, data: 32'h44332211});
        send_byte(8'hA5, 1'b0, 1); send_byte(8'h01, 1'b0, 1); send_byte(8'h00, 1'b0, 1);
        send_byte(8'h11, 1'b0, 1); send_byte(8'h22, 1'b0, 1); send_byte(8'h33, 1'b0, 1);
        send_byte(8'h44, 1'b0, 0);
        chk("lat mem_we", {31'd0, mem_we}, 32'd1);
        chk("lat hold during write", {31'd0, core_hold}, 32'd1);
        chk("lat mem_addr", mem_addr, 32'h0);
        idle(1);
        chk("lat mem_we off", {31'd0, mem_we}, 32'd0);
        chk("lat hold released", {31'd0, core_hold}, 32'd0);
        chk("lat load_done", {31'd0, load_done}, 32'd1);
        check_sb("lat");

        // RUN: fetch mux, rx ignored, reload re-holds and reloads from 0
        fetch_addr = 32'h40;
        #1 chk("run mem_addr fetch", mem_addr, 32'h40);
        send_byte(8'hA5, 1'b0, 2);
        chk("run ignores rx", {31'd0, core_hold}, 32'd0);
        pulse_reload();
        chk("reload core_hold", {31'd0, core_hold}, 32'd1);
        chk("reload load_done", {31'd0, load_done}, 32'd0);
        exp_q.push_back('{addr: 32'h0, data: 32'hCAFEBABE});
        send_byte(8'hA5, 1'b0, 1); send_byte(8'h01, 1'b0, 1); send_byte(8'h00, 1'b0, 1);
        send_byte(8'hBE, 1'b0, 1); send_byte(8'hBA, 1'b0, 1); send_byte(8'hFE, 1'b0, 1);
        send_byte(8'hCA, 1'b0, 3);
        check_sb("reload frame");
        chk("reload frame done", {31'd0, load_done}, 32'd1);

        // inter-byte timeout boundary, then recovery
        pulse_reload();
        send_byte(8'hA5, 1'b0, 1); send_byte(8'h02, 1'b0, 1); send_byte(8'h00, 1'b0, 1);
        send_byte(8'h11, 1'b0, 1); send_byte(8'h22, 1'b0, 0);
        idle(99);
        chk("timeout not yet", {31'd0, load_error}, 32'd0);
        idle(1);
        chk("timeout error", {31'd0, load_error}, 32'd1);
        chk("timeout hold", {31'd0, core_hold}, 32'd1);
        chk("timeout words", {16'd0, words_loaded}, 32'd0);
        check_sb("timeout");
        exp_q.push_back('{addr: 32'h0, data: 32'h04030201});
        send_byte(8'hA5, 1'b0, 1);
        chk("timeout err cleared", {31'd0, load_error}, 32'd0);
        send_byte(8'h01, 1'b0, 1); send_byte(8'h00, 1'b0, 1);
        send_byte(8'h01, 1'b0, 1); send_byte(8'h02, 1'b0, 1); send_byte(8'h03, 1'b0, 1);
        send_byte(8'h04, 1'b0, 3);
        check_sb("recover");
        chk("recover done", {31'd0, load_done}, 32'd1);

        // framing error on third byte of word 1
        pulse_reload();
        exp_q.push_back('{addr: 32'h0, data: 32'h12345678});
        send_byte(8'hA5, 1'b0, 1); send_byte(8'h02, 1'b0, 1); send_byte(8'h00, 1'b0, 1);
        send_byte(8'h78, 1'b0, 1); send_byte(8'h56, 1'b0, 1); send_byte(8'h34, 1'b0, 1);
        send_byte(8'h12, 1'b0, 1);
        send_byte(8'h9A, 1'b0, 1); send_byte(8'hBC, 1'b0, 1); send_byte(8'hDE, 1'b1, 1);
        send_byte(8'hF0, 1'b0, 3);
        check_sb("ferr");
        chk("ferr error", {31'd0, load_error}, 32'd1);
        chk("ferr words", {16'd0, words_loaded}, 32'd1);
        chk("ferr hold", {31'd0, core_hold}, 32'd1);
        chk("ferr done", {31'd0, load_done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
